// File: rtl/scpu_spi_multi_ch_serializer.sv
// scpu_spi_multi_ch_serializer
// Serialises up to NUM_CH words of DATA_WIDTH bits, MSB first, onto SPI_SO using
// two non-overlapping shift clocks (SCLK1/SCLK2) and ends each frame with a LAT
// strobe and a one-cycle RDY pulse. Channels whose CH_MASK bit is 0 are skipped.
// Optional feature macro: SCPU_SPI_READBACK_EN adds SPI_SI/RD_PO serial capture.
module scpu_spi_multi_ch_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int CLK_DIV    = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         BGN,
   input  logic [NUM_CH*DATA_WIDTH-1:0] DATA_PI,
   input  logic [NUM_CH-1:0]            CH_MASK,
`ifdef SCPU_SPI_READBACK_EN
   input  logic                         SPI_SI,
   output logic [NUM_CH*DATA_WIDTH-1:0] RD_PO,
`endif
   output logic                         BUSY,
   output logic                         RDY,
   output logic                         SCLK1,
   output logic                         SCLK2,
   output logic                         LAT,
   output logic                         SPI_SO
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TOT_W = NUM_CH * DATA_WIDTH;
   localparam int IDX_W = (TOT_W > 1) ? $clog2(TOT_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETUP, S_P1, S_GAP, S_P2, S_LATCH, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CH_W-1:0]    chIdx_q, chIdx_d;
   logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
   logic [PH_W-1:0]    phaseCnt_q, phaseCnt_d;
   logic [TOT_W-1:0]   dataSnap_q, dataSnap_d;
   logic [NUM_CH-1:0]  maskSnap_q, maskSnap_d;
   logic               phaseLast;
   logic [CH_W:0]      firstCh;
   logic [CH_W:0]      nextCh;
   logic [IDX_W-1:0]   selIdx;
   logic               soD;

   // Lowest enabled channel at or above 'from'; the top bit flags that one was found.
   function automatic logic [CH_W:0] findCh(input logic [NUM_CH-1:0] m, input int from);
      logic [CH_W:0] res;
      res = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (i >= from && m[i]) res = {1'b1, CH_W'(i)};
      end
      return res;
   endfunction

   // Next-state logic: phase sequencing, bit/channel stepping and the snapshot taken when a request is accepted.
   always_comb begin
      state_d    = state_q;
      chIdx_d    = chIdx_q;
      bitCnt_d   = bitCnt_q;
      phaseCnt_d = phaseCnt_q;
      dataSnap_d = dataSnap_q;
      maskSnap_d = maskSnap_q;
      phaseLast  = (phaseCnt_q == PH_W'(CLK_DIV - 1));
      firstCh    = findCh(maskSnap_q, 0);
      nextCh     = findCh(maskSnap_q, int'(chIdx_q) + 1);
      case (state_q)
         S_IDLE: begin
            if (BGN) begin
               state_d    = S_LOAD;
               dataSnap_d = DATA_PI;
               maskSnap_d = CH_MASK;
            end
         end
         S_LOAD: begin
            phaseCnt_d = '0;
            bitCnt_d   = BIT_W'(DATA_WIDTH - 1);
            if (firstCh[CH_W]) begin
               chIdx_d = firstCh[CH_W-1:0];
               state_d = S_SETUP;
            end else begin
               state_d = S_DONE;
            end
         end
         S_SETUP, S_P1, S_GAP: begin
            if (phaseLast) begin
               phaseCnt_d = '0;
               state_d    = (state_q == S_SETUP) ? S_P1 : (state_q == S_P1) ? S_GAP : S_P2;
            end else begin
               phaseCnt_d = phaseCnt_q + 1'b1;
            end
         end
         S_P2: begin
            if (phaseLast) begin
               phaseCnt_d = '0;
               if (bitCnt_q != '0) begin
                  bitCnt_d = bitCnt_q - 1'b1;
                  state_d  = S_SETUP;
               end else if (nextCh[CH_W]) begin
                  chIdx_d  = nextCh[CH_W-1:0];
                  bitCnt_d = BIT_W'(DATA_WIDTH - 1);
                  state_d  = S_SETUP;
               end else begin
                  state_d = S_LATCH;
               end
            end else begin
               phaseCnt_d = phaseCnt_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (phaseLast) begin
               phaseCnt_d = '0;
               state_d    = S_DONE;
            end else begin
               phaseCnt_d = phaseCnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      selIdx = IDX_W'(int'(chIdx_d) * DATA_WIDTH + int'(bitCnt_d));
      soD    = 1'b0;
      if (state_d == S_SETUP || state_d == S_P1 || state_d == S_GAP || state_d == S_P2) begin
         soD = dataSnap_q[selIdx];
      end
   end

   // State and counter registers; outputs are registered from the upcoming state so they line up with it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         chIdx_q    <= '0;
         bitCnt_q   <= '0;
         phaseCnt_q <= '0;
         dataSnap_q <= '0;
         maskSnap_q <= '0;
         BUSY       <= 1'b0;
         RDY        <= 1'b0;
         SCLK1      <= 1'b0;
         SCLK2      <= 1'b0;
         LAT        <= 1'b0;
         SPI_SO     <= 1'b0;
      end else begin
         state_q    <= state_d;
         chIdx_q    <= chIdx_d;
         bitCnt_q   <= bitCnt_d;
         phaseCnt_q <= phaseCnt_d;
         dataSnap_q <= dataSnap_d;
         maskSnap_q <= maskSnap_d;
         BUSY       <= (state_d != S_IDLE);
         RDY        <= (state_d == S_DONE);
         SCLK1      <= (state_d == S_P1);
         SCLK2      <= (state_d == S_P2);
         LAT        <= (state_d == S_LATCH);
         SPI_SO     <= soD;
      end
   end

`ifdef SCPU_SPI_READBACK_EN
   logic [TOT_W-1:0] rdShift_q;

   // Readback capture: one SPI_SI bit per shifted bit, taken at the very end of the SCLK2 phase.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rdShift_q <= '0;
      end else if (state_q == S_LOAD) begin
         rdShift_q <= '0;
      end else if (state_q == S_P2 && phaseLast) begin
         rdShift_q <= {rdShift_q[TOT_W-2:0], SPI_SI};
      end
   end

   assign RD_PO = rdShift_q;
`endif

endmodule

// File: tb/tb_scpu_spi_multi_ch_serializer.sv
// tb_scpu_spi_multi_ch_serializer
// Directed bench: DATA_WIDTH=8, NUM_CH=2; one instance with CLK_DIV=1 and one with CLK_DIV=3.
// Define SCPU_SPI_READBACK_EN to also cover the readback path.
module tb_scpu_spi_multi_ch_serializer;

   logic clk = 1'b0;
   logic rst;
   logic bgn1, bgn3;
   logic [15:0] data1, data3;
   logic [1:0] mask1, mask3;
   logic busy1, rdy1, s11, s21, lat1, so1;
   logic busy3, rdy3, s13, s23, lat3, so3;
`ifdef SCPU_SPI_READBACK_EN
   logic [15:0] rd1, rd3;
`endif

   int assertCount = 0;
   int failCount   = 0;
   int sel         = 0;

   logic obsBusy, obsRdy, obsS1, obsS2, obsLat, obsSo;
   assign obsBusy = (sel == 0) ? busy1 : busy3;
   assign obsRdy  = (sel == 0) ? rdy1  : rdy3;
   assign obsS1   = (sel == 0) ? s11   : s13;
   assign obsS2   = (sel == 0) ? s21   : s23;
   assign obsLat  = (sel == 0) ? lat1  : lat3;
   assign obsSo   = (sel == 0) ? so1   : so3;

   // Free-running system clock.
   always #5 clk = ~clk;

   scpu_spi_multi_ch_serializer #(.DATA_WIDTH(8), .NUM_CH(2), .CLK_DIV(1)) dut1 (
      .CLK(clk), .RST(rst), .BGN(bgn1), .DATA_PI(data1), .CH_MASK(mask1),
`ifdef SCPU_SPI_READBACK_EN
      .SPI_SI(so1), .RD_PO(rd1),
`endif
      .BUSY(busy1), .RDY(rdy1), .SCLK1(s11), .SCLK2(s21), .LAT(lat1), .SPI_SO(so1)
   );

   scpu_spi_multi_ch_serializer #(.DATA_WIDTH(8), .NUM_CH(2), .CLK_DIV(3)) dut3 (
      .CLK(clk), .RST(rst), .BGN(bgn3), .DATA_PI(data3), .CH_MASK(mask3),
`ifdef SCPU_SPI_READBACK_EN
      .SPI_SI(so3), .RD_PO(rd3),
`endif
      .BUSY(busy3), .RDY(rdy3), .SCLK1(s13), .SCLK2(s23), .LAT(lat3), .SPI_SO(so3)
   );

   // The two shift clocks must never overlap on either instance.
   always @(negedge clk) begin
      if (!rst) begin
         assert (!(s11 && s21)) else $error("[TB] FAIL overlap dut1");
         assert (!(s13 && s23)) else $error("[TB] FAIL overlap dut3");
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Fires one BGN on the selected instance (cycle 0) and checks the whole frame.
   task automatic applyStimulus(input string tag, input int expRdy, input int expLat,
                                input logic [15:0] expBits, input int expN, input int div);
      int nS1 = 0, nS2 = 0, s1High = 0, latCnt = 0, latFirst = -1;
      int rdyCnt = 0, rdyCyc = -1, busyErr = 0, ovl = 0;
      logic pS1 = 1'b0, pS2 = 1'b0;
      logic [15:0] bits = '0;
      @(negedge clk);
      if (sel == 0) bgn1 = 1'b1; else bgn3 = 1'b1;
      for (int cyc = 1; cyc <= expRdy + 3; cyc++) begin
         @(negedge clk);
         bgn1 = 1'b0;
         bgn3 = 1'b0;
         if (obsS1 && !pS1) begin
            nS1++;
            bits = {bits[14:0], obsSo};
         end
         if (obsS2 && !pS2) nS2++;
         if (obsS1) s1High++;
         if (obsLat) begin
            latCnt++;
            if (latFirst < 0) latFirst = cyc;
         end
         if (obsRdy) begin
            rdyCnt++;
            rdyCyc = cyc;
         end
         if (obsBusy !== (cyc <= expRdy)) busyErr++;
         if (obsS1 && obsS2) ovl++;
         pS1 = obsS1;
         pS2 = obsS2;
      end
      checkOutput({tag, ".bits"},     32'(bits),     32'(expBits));
      checkOutput({tag, ".nSclk1"},   nS1,           expN);
      checkOutput({tag, ".nSclk2"},   nS2,           expN);
      checkOutput({tag, ".s1High"},   s1High,        expN * div);
      checkOutput({tag, ".latFirst"}, latFirst,      expLat);
      checkOutput({tag, ".latCnt"},   latCnt,        (expLat < 0) ? 0 : div);
      checkOutput({tag, ".rdyCyc"},   rdyCyc,        expRdy);
      checkOutput({tag, ".rdyCnt"},   rdyCnt,        1);
      checkOutput({tag, ".busyErr"},  busyErr,       0);
      checkOutput({tag, ".overlap"},  ovl,           0);
      checkOutput({tag, ".soIdle"},   32'(obsSo),    0);
   endtask

   initial begin
      int latSeen, rdySeen, rdyN;
      int rdyAt[3];
      logic [15:0] f1Bits, f2Bits;
      logic pS1;

      rst = 1'b1; bgn1 = 1'b0; bgn3 = 1'b0;
      data1 = '0; data3 = '0; mask1 = '0; mask3 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset.dut1", {26'b0, busy1, rdy1, s11, s21, lat1, so1}, 0);
      checkOutput("reset.dut3", {26'b0, busy3, rdy3, s13, s23, lat3, so3}, 0);
`ifdef SCPU_SPI_READBACK_EN
      checkOutput("reset.rd1", 32'(rd1), 0);
`endif

      // Full two-channel frame, partial mask, and empty mask.
      sel = 0;
      data1 = 16'h3CA5; mask1 = 2'b11;
      applyStimulus("full", 67, 66, 16'hA53C, 16, 1);
      mask1 = 2'b10;
      applyStimulus("mask10", 35, 34, 16'h003C, 8, 1);
      mask1 = 2'b00;
      applyStimulus("mask00", 2, -1, 16'h0000, 0, 1);

      // Slow divider instance.
      sel = 1;
      data3 = 16'h00FF; mask3 = 2'b01;
      applyStimulus("div3", 101, 98, 16'h00FF, 8, 3);
      sel = 0;

      // Reset mid-frame aborts without LAT/RDY, then a fresh frame runs normally.
      data1 = 16'h3CA5; mask1 = 2'b11;
      latSeen = 0; rdySeen = 0;
      @(negedge clk);
      bgn1 = 1'b1;
      for (int cyc = 1; cyc <= 21; cyc++) begin
         @(negedge clk);
         bgn1 = 1'b0;
         if (lat1) latSeen++;
         if (rdy1) rdySeen++;
         if (cyc == 20) begin
            checkOutput("abort.busyBefore", 32'(busy1), 1);
            rst = 1'b1;
         end
         if (cyc == 21) begin
            rst = 1'b0;
            checkOutput("abort.outputs", {26'b0, busy1, rdy1, s11, s21, lat1, so1}, 0);
         end
      end
      checkOutput("abort.noLatRdy", latSeen + rdySeen, 0);
      applyStimulus("restart", 67, 66, 16'hA53C, 16, 1);

      // BGN held high: back-to-back frames; data changed mid-frame must not disturb frame 1.
      rdyN = 0; rdyAt[0] = -1; rdyAt[1] = -1; rdyAt[2] = -1;
      f1Bits = '0; f2Bits = '0; pS1 = 1'b0;
      @(negedge clk);
      bgn1 = 1'b1;
      for (int cyc = 1; cyc <= 206; cyc++) begin
         @(negedge clk);
         if (cyc == 10) data1 = 16'hFFFF;
         if (cyc == 200) bgn1 = 1'b0;
         if (s11 && !pS1) begin
            if (cyc <= 67) f1Bits = {f1Bits[14:0], so1};
            else if (cyc <= 135) f2Bits = {f2Bits[14:0], so1};
         end
         pS1 = s11;
         if (rdy1) begin
            if (rdyN < 3) rdyAt[rdyN] = cyc;
            rdyN++;
         end
      end
      checkOutput("b2b.rdyN",   rdyN, 3);
      checkOutput("b2b.rdy0",   rdyAt[0], 67);
      checkOutput("b2b.rdy1",   rdyAt[1], 135);
      checkOutput("b2b.rdy2",   rdyAt[2], 203);
      checkOutput("b2b.frame1", 32'(f1Bits), 32'h0000A53C);
      checkOutput("b2b.frame2", 32'(f2Bits), 32'h0000FFFF);
      checkOutput("b2b.idle",   32'(busy1), 0);

`ifdef SCPU_SPI_READBACK_EN
      // Loopback readback.
      data1 = 16'h3CA5; mask1 = 2'b11;
      applyStimulus("rb11", 67, 66, 16'hA53C, 16, 1);
      checkOutput("rb11.rd", 32'(rd1), 32'h0000A53C);
      mask1 = 2'b01;
      applyStimulus("rb01", 35, 34, 16'h00A5, 8, 1);
      checkOutput("rb01.rd", 32'(rd1), 32'h000000A5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
